// File: rtl/uart_tx_frame_if.sv
// Handshake and line signals between a word source and the UART transmit frame engine.
// The source (master) presents a word and frame options; the engine (slave) drives the line and status.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  TX_READY;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        input  TX_OUT, TX_READY, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        output TX_OUT, TX_READY, BUSY
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits.
// One bit per CLK; TX_OUT is registered and shows the bit of the state entered at each edge.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input logic           CLK,
    input logic           RST,
    uart_tx_frame_if.slave tx
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic                  par_en_reg, par_en_next;
    logic                  parity_reg, parity_next;
    logic                  stop2_reg, stop2_next;
    logic                  tx_out_reg, tx_out_next;
    logic                  tx_ready_reg, tx_ready_next;
    logic                  busy_reg, busy_next;

    logic [DATA_WIDTH-1:0] data_ordered;
    logic                  accept;

    // Reorder the word at load so the serializer always shifts out bit 0 first.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign data_ordered[gi] = tx.P_DATA[gi];
            end else begin : g_msb
                assign data_ordered[gi] = tx.P_DATA[DATA_WIDTH-1-gi];
            end
        end
    endgenerate

    assign accept = tx.DATA_VALID && tx_ready_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            par_en_reg   <= 1'b0;
            parity_reg   <= 1'b0;
            stop2_reg    <= 1'b0;
            tx_out_reg   <= 1'b1;
            tx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_en_reg   <= par_en_next;
            parity_reg   <= parity_next;
            stop2_reg    <= stop2_next;
            tx_out_reg   <= tx_out_next;
            tx_ready_reg <= tx_ready_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        par_en_next   = par_en_reg;
        parity_next   = parity_reg;
        stop2_next    = stop2_reg;
        tx_out_next   = tx_out_reg;
        tx_ready_next = tx_ready_reg;
        busy_next     = busy_reg;

        case (state_reg)
            IDLE: begin
                tx_out_next = 1'b1;
            end
            START: begin
                state_next   = DATA;
                tx_out_next  = shift_reg[0];
                shift_next   = shift_reg >> 1;
                bit_cnt_next = '0;
            end
            DATA: begin
                if (bit_cnt_reg == CW'(DATA_WIDTH - 1)) begin
                    if (par_en_reg) begin
                        state_next  = PARITY;
                        tx_out_next = parity_reg;
                    end else begin
                        state_next    = STOP;
                        tx_out_next   = 1'b1;
                        tx_ready_next = !stop2_reg;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    tx_out_next  = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                end
            end
            PARITY: begin
                state_next    = STOP;
                tx_out_next   = 1'b1;
                tx_ready_next = !stop2_reg;
            end
            STOP: begin
                // tx_ready_reg high here marks the final stop bit.
                if (tx_ready_reg) begin
                    state_next  = IDLE;
                    tx_out_next = 1'b1;
                    busy_next   = 1'b0;
                end else begin
                    tx_ready_next = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                tx_out_next   = 1'b1;
                tx_ready_next = 1'b1;
                busy_next     = 1'b0;
            end
        endcase

        // Ready is only high in IDLE or the final stop bit, so this covers both load points.
        if (accept) begin
            state_next    = START;
            shift_next    = data_ordered;
            par_en_next   = tx.PAR_EN;
            parity_next   = (^tx.P_DATA) ^ tx.PAR_TYP;
            stop2_next    = tx.STOP2;
            tx_out_next   = 1'b0;
            tx_ready_next = 1'b0;
            busy_next     = 1'b1;
        end
    end

    assign tx.TX_OUT   = tx_out_reg;
    assign tx.TX_READY = tx_ready_reg;
    assign tx.BUSY     = busy_reg;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: two instances (8-bit LSB-first, 7-bit MSB-first) checked cycle by cycle.
module tb_uart_tx_frame;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_tx_frame_if #(.DATA_WIDTH(8)) if0 ();
    uart_tx_frame_if #(.DATA_WIDTH(7)) if1 ();

    uart_tx_frame #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut0 (.CLK(CLK), .RST(RST), .tx(if0));
    uart_tx_frame #(.DATA_WIDTH(7), .LSB_FIRST(1'b0)) dut1 (.CLK(CLK), .RST(RST), .tx(if1));

    // Each expected entry is {TX_OUT, TX_READY, BUSY} for one line cycle.
    localparam logic [2:0] IDLE_T = 3'b110;
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    bit  mon_en   = 1'b0;

    task automatic push(input int which, input logic [2:0] t);
        if (which == 0) q0.push_back(t);
        else            q1.push_back(t);
    endtask

    // Reference frame built from the frame rules: start, ordered data, parity, stop bits.
    task automatic model(input int which, input logic [8:0] d, input bit pe, input bit pt, input bit s2);
        int dw;
        bit lsb;
        int ones;
        int idx;
        bit b;
        dw   = (which == 0) ? 8 : 7;
        lsb  = (which == 0);
        ones = 0;
        push(which, 3'b001);
        for (int i = 0; i < dw; i++) begin
            idx  = lsb ? i : dw - 1 - i;
            b    = d[idx];
            ones = ones + int'(b);
            push(which, {b, 1'b0, 1'b1});
        end
        if (pe) push(which, {((ones % 2) == 1) ^ pt, 1'b0, 1'b1});
        if (s2) push(which, 3'b101);
        push(which, 3'b111);
    endtask

    task automatic check_one(input int which);
        logic [2:0] expv;
        logic [2:0] got;
        if (which == 0) begin
            expv = (q0.size() > 0) ? q0.pop_front() : IDLE_T;
            got  = {if0.TX_OUT, if0.TX_READY, if0.BUSY};
        end else begin
            expv = (q1.size() > 0) ? q1.pop_front() : IDLE_T;
            got  = {if1.TX_OUT, if1.TX_READY, if1.BUSY};
        end
        chk_cnt++;
        if (got === expv) pass_cnt++;
        else $display("FAIL dut%0d_line t=%0t: got tx/ready/busy=%b required %b", which, $time, got, expv);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            check_one(0);
            check_one(1);
        end
    end

    task automatic drive(input int which, input logic [8:0] d, input bit pe, input bit pt,
                         input bit s2, input bit v);
        if (which == 0) begin
            if0.P_DATA = d[7:0]; if0.PAR_EN = pe; if0.PAR_TYP = pt; if0.STOP2 = s2; if0.DATA_VALID = v;
        end else begin
            if1.P_DATA = d[6:0]; if1.PAR_EN = pe; if1.PAR_TYP = pt; if1.STOP2 = s2; if1.DATA_VALID = v;
        end
    endtask

    // Present a word, wait (bounded) for the accept edge, record the expected frame.
    task automatic send(input int which, input logic [8:0] d, input bit pe, input bit pt,
                        input bit s2, input bit keep, input string name);
        bit accepted;
        bit rdy;
        int waited;
        accepted = 1'b0;
        waited   = 0;
        drive(which, d, pe, pt, s2, 1'b1);
        while (!accepted && waited < 100) begin
            @(negedge CLK);
            rdy = (which == 0) ? if0.TX_READY : if1.TX_READY;
            if (rdy) begin
                #1;
                model(which, d, pe, pt, s2);
                accepted = 1'b1;
            end
            waited++;
        end
        if (!accepted) begin
            chk_cnt++;
            $display("FAIL %s_accept: got TX_READY=0 for 100 cycles required 1", name);
        end
        @(posedge CLK);
        #1;
        if (!keep) drive(which, d, pe, pt, s2, 1'b0);
    endtask

    initial begin
        int which;
        int n;
        int waited;
        drive(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        send(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, "even_a5");
        repeat (13) @(posedge CLK);
        #1;
        send(0, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, "odd_stop2");
        repeat (14) @(posedge CLK);
        #1;
        send(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_00");
        send(0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_ff");
        repeat (12) @(posedge CLK);
        #1;

        // Inputs change and valid is raised mid-frame; the new word must wait for TX_READY.
        send(0, 9'h03C, 1'b1, 1'b0, 1'b0, 1'b0, "mid_3c");
        repeat (3) @(posedge CLK);
        #1;
        send(0, 9'h099, 1'b0, 1'b1, 1'b1, 1'b0, "mid_99");
        repeat (14) @(posedge CLK);
        #1;

        // Reset during the 4th data bit.
        send(0, 9'h0C3, 1'b1, 1'b0, 1'b1, 1'b0, "rst_c3");
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q0.delete();
        send(0, 9'h055, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_55");
        repeat (12) @(posedge CLK);
        #1;

        send(1, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0, "w7_41");
        repeat (11) @(posedge CLK);
        #1;
        send(1, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, "w7_odd_zero");
        repeat (11) @(posedge CLK);
        #1;

        for (int it = 0; it < 24; it++) begin
            which = int'($urandom_range(0, 1));
            n     = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                send(which, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     (k != n - 1), "rand");
            end
            repeat ($urandom_range(0, 4)) @(posedge CLK);
            #1;
        end

        waited = 0;
        while ((q0.size() > 0 || q1.size() > 0) && waited < 200) begin
            @(posedge CLK);
            waited++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: got %0d/%0d entries left required 0/0", q0.size(), q1.size());
        end
        repeat (3) @(posedge CLK);
        #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmit frame engine: serializer, parity generator, frame FSM and registered line-driver select in one block.
- Takes a parallel word with a valid handshake and drives a complete UART frame on TX_OUT: start, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits.
- One bit per CLK cycle. CLK is the UART TX clock already divided by prescale upstream.
- Sits in the UART Tx path between the SYS_CTRL/FIFO read side and the serial pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- LSB_FIRST, 1, 1 = data bit 0 transmitted first; 0 = MSB first.

Ports:
- CLK  in  1  TX clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  in  1  P_DATA valid; a transfer occurs on an edge where DATA_VALID && TX_READY.
- PAR_EN  in  1  1 = parity bit inserted.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits, 0 = one.
- TX_OUT  out  1  registered serial line.
- TX_READY  out  1  registered; block can accept a word at the next edge.
- BUSY  out  1  registered; high while a frame is on the line.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - TX_OUT=1 (idle mark), TX_READY=1, BUSY=0, state=IDLE.
  - Bit counter and shift register cleared.
  - Overrides any frame in progress; the line returns high at the following edge.
- States: IDLE, START, DATA, PARITY, STOP.
- TX_OUT is registered and always carries the bit of the state being entered at that edge, so there is no combinational path from inputs to TX_OUT.
- Accept edge:
  - Condition: DATA_VALID && TX_READY.
  - Latches P_DATA, PAR_EN, PAR_TYP, STOP2. Input changes after this edge do not affect the current frame.
  - Computes parity = ^P_DATA ^ PAR_TYP.
  - Enters START: TX_OUT<=0, BUSY<=1, TX_READY<=0.
- START -> DATA after 1 cycle.
  - DATA lasts DATA_WIDTH cycles.
  - Bit order: LSB first when LSB_FIRST=1, else MSB first.
  - Bit counter 0..DATA_WIDTH-1.
- DATA -> PARITY (1 cycle) if latched PAR_EN, else DATA -> STOP.
- STOP lasts 1 cycle, or 2 cycles if latched STOP2. TX_OUT=1 throughout.
- Frame length F = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles, measured from the accept edge to the edge ending the last stop bit.
- TX_READY:
  - High in IDLE and during the final stop-bit cycle.
  - Low otherwise, including the first stop bit when STOP2=1.
- Edge ending the final stop bit:
  - If DATA_VALID=1: new word accepted, START entered directly, TX_OUT<=0, BUSY stays 1. Back-to-back frames have no idle gap.
  - Else: IDLE, TX_OUT<=1, BUSY<=0, TX_READY stays 1.
- DATA_VALID while TX_READY=0 is ignored. The source must hold DATA_VALID until a transfer occurs.
- Parity covers exactly DATA_WIDTH bits. An odd-parity frame with all-zero data sends parity bit 1.

Test Plan:
- Even parity, LSB first: RST 2 cycles, then P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0, DATA_VALID for 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. F=11. BUSY high for 11 cycles, then TX_OUT=1, BUSY=0.
- Odd parity, two stop bits: P_DATA=0x01, PAR_EN=1, PAR_TYP=1, STOP2=1 -> 0,1,0,0,0,0,0,0,0,0,1,1. Parity=0. F=12. TX_READY low on first stop bit, high on second.
- No parity, back-to-back: PAR_EN=0, DATA_VALID held high with 0x00 then 0xFF -> 0,0×8,1,0,1×8,1. Single stop bit between frames, no idle cycle, BUSY never drops.
- Mid-frame input change / ignored valid: change P_DATA, PAR_EN and DATA_VALID during the DATA state of 0x3C -> transmitted frame unchanged (0x3C with original config). No new frame accepted until TX_READY.
- Reset mid-frame: assert RST during the 4th data bit -> TX_OUT=1, BUSY=0, TX_READY=1 at the next edge. A new 0x55 frame after release is transmitted correctly.
- DATA_WIDTH=7, LSB_FIRST=0, even parity, P_DATA=0x41 -> 0,1,0,0,0,0,0,1,0,1. Parity=0. F=10.
